// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive controller.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    localparam int PRESC_8  = 8;
    localparam int PRESC_16 = 16;
    localparam int PRESC_32 = 32;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversampling edge counter, data bit counter and 3-sample majority voter
// for the UART receiver.
module uart_rx_edge_bit_cnt #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  active,
    input  logic                  in_data,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  end_of_bit,
    output logic                  sample_pt,
    output logic                  last_bit,
    output logic                  majority
);

    localparam int BIT_W = $clog2(DATA_WIDTH + 1);

    logic [PRESCALE_W-1:0] edge_cnt;
    logic [PRESCALE_W-1:0] half;
    logic [BIT_W-1:0]      bit_cnt;
    logic [2:0]            samples;

    assign half       = prescale >> 1;
    assign end_of_bit = active && (edge_cnt == prescale - PRESCALE_W'(1));
    assign sample_pt  = active && (edge_cnt == half + PRESCALE_W'(2));
    assign last_bit   = (bit_cnt == BIT_W'(DATA_WIDTH - 1));
    assign majority   = (samples[0] & samples[1]) | (samples[0] & samples[2]) |
                        (samples[1] & samples[2]);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt <= '0;
        end else if (!active || end_of_bit) begin
            edge_cnt <= '0;
        end else begin
            edge_cnt <= edge_cnt + PRESCALE_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bit_cnt <= '0;
        end else if (!in_data) begin
            bit_cnt <= '0;
        end else if (end_of_bit) begin
            bit_cnt <= bit_cnt + BIT_W'(1);
        end
    end

    // Three samples straddle mid-bit so a single-cycle glitch is outvoted.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            samples <= '0;
        end else if (active) begin
            if (edge_cnt == half - PRESCALE_W'(1)) samples[0] <= rx_in;
            if (edge_cnt == half)                  samples[1] <= rx_in;
            if (edge_cnt == half + PRESCALE_W'(1)) samples[2] <= rx_in;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: frame FSM, deserialiser, parity/stop checks and
// the output word register with its one-cycle valid strobe.
module uart_rx_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] PRESCALE,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_VALID,
    output logic                  PAR_ERR,
    output logic                  STP_ERR
);

    import uart_rx_pkg::*;

    rx_state_e state, next_state;

    logic [PRESCALE_W-1:0] presc_n, presc_q;
    logic                  par_en_q, par_typ_q;
    logic                  end_of_bit, sample_pt, last_bit, majority;
    logic [DATA_WIDTH-1:0] shift;
    logic                  par_fail, stp_fail, par_exp;
    logic                  start_entry, shift_en, par_check, stp_check, frame_done;

    uart_rx_edge_bit_cnt #(
        .DATA_WIDTH(DATA_WIDTH),
        .PRESCALE_W(PRESCALE_W)
    ) u_cnt (
        .CLK       (CLK),
        .RST       (RST),
        .active    (state != IDLE),
        .in_data   (state == DATA),
        .rx_in     (RX_IN),
        .prescale  (presc_q),
        .end_of_bit(end_of_bit),
        .sample_pt (sample_pt),
        .last_bit  (last_bit),
        .majority  (majority)
    );

    always_comb begin
        presc_n = PRESCALE_W'(PRESC_8);
        if (PRESCALE == PRESCALE_W'(PRESC_16))      presc_n = PRESCALE_W'(PRESC_16);
        else if (PRESCALE == PRESCALE_W'(PRESC_32)) presc_n = PRESCALE_W'(PRESC_32);
    end

    assign par_exp = (^shift) ^ (par_typ_q == PAR_ODD);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!RX_IN) next_state = START;
            START:   if (end_of_bit) next_state = majority ? IDLE : DATA;
            DATA:    if (end_of_bit && last_bit) next_state = par_en_q ? PARITY : STOP;
            PARITY:  if (end_of_bit) next_state = STOP;
            STOP:    if (end_of_bit) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        start_entry = 1'b0;
        shift_en    = 1'b0;
        par_check   = 1'b0;
        stp_check   = 1'b0;
        frame_done  = 1'b0;
        case (state)
            IDLE:   start_entry = !RX_IN;
            DATA:   shift_en    = sample_pt;
            PARITY: par_check   = sample_pt;
            STOP: begin
                stp_check  = sample_pt;
                frame_done = end_of_bit;
            end
            default: ;
        endcase
    end

    // Frame configuration is frozen at the start edge so mid-frame input changes are ignored.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            presc_q   <= PRESCALE_W'(PRESC_8);
            par_en_q  <= 1'b0;
            par_typ_q <= PAR_EVEN;
            shift     <= '0;
            par_fail  <= 1'b0;
            stp_fail  <= 1'b0;
        end else begin
            if (start_entry) begin
                presc_q   <= presc_n;
                par_en_q  <= PAR_EN;
                par_typ_q <= PAR_TYP;
                par_fail  <= 1'b0;
                stp_fail  <= 1'b0;
            end
            if (shift_en)                          shift    <= {majority, shift[DATA_WIDTH-1:1]};
            if (par_check && (majority != par_exp)) par_fail <= 1'b1;
            if (stp_check && !majority)             stp_fail <= 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            P_DATA     <= '0;
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;
        end else begin
            DATA_VALID <= 1'b0;
            if (frame_done) begin
                PAR_ERR <= par_fail;
                STP_ERR <= stp_fail;
                if (!par_fail && !stp_fail) begin
                    P_DATA     <= shift;
                    DATA_VALID <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed scenarios plus randomized
// frames checked against a frame-level reference model.
module tb_uart_rx_ctrl;

    localparam int DW = 8;
    localparam int PW = 6;

    logic          CLK      = 1'b0;
    logic          RST      = 1'b0;
    logic          RX_IN    = 1'b1;
    logic [PW-1:0] PRESCALE = 6'd8;
    logic          PAR_EN   = 1'b0;
    logic          PAR_TYP  = 1'b0;
    logic [DW-1:0] P_DATA;
    logic          DATA_VALID;
    logic          PAR_ERR;
    logic          STP_ERR;

    int     n_cmp  = 0;
    int     n_fail = 0;
    longint cyc    = 0;

    logic [DW-1:0] dv_data[$];
    longint        dv_cyc[$];

    logic [DW-1:0] exp_pdata   = '0;
    bit            exp_par_err = 1'b0;
    bit            exp_stp_err = 1'b0;

    uart_rx_ctrl #(
        .DATA_WIDTH(DW),
        .PRESCALE_W(PW)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .RX_IN     (RX_IN),
        .PRESCALE  (PRESCALE),
        .PAR_EN    (PAR_EN),
        .PAR_TYP   (PAR_TYP),
        .P_DATA    (P_DATA),
        .DATA_VALID(DATA_VALID),
        .PAR_ERR   (PAR_ERR),
        .STP_ERR   (STP_ERR)
    );

    always #5 CLK = ~CLK;

    // Every valid strobe is logged with the cycle it was seen in.
    always @(posedge CLK) begin
        cyc++;
        #1;
        if (DATA_VALID === 1'b1) begin
            dv_data.push_back(P_DATA);
            dv_cyc.push_back(cyc);
        end
    end

    function automatic int eff_prescale(input int p);
        return (p == 16 || p == 32) ? p : 8;
    endfunction

    function automatic bit parity_bit(input logic [DW-1:0] data, input bit ptyp);
        return (($countones(data) % 2) == 1) ^ ptyp;
    endfunction

    task automatic model_frame(input logic [DW-1:0] data, input bit pen, input bit ptyp,
                               input bit par_bit, input bit stop_bit, output bit good);
        bit pf, sf;
        pf = pen && (par_bit != parity_bit(data, ptyp));
        sf = !stop_bit;
        good = !pf && !sf;
        if (good) exp_pdata = data;
        exp_par_err = pf;
        exp_stp_err = sf;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            RX_IN = 1'b1;
        end
    endtask

    task automatic send_bit(input logic value, input int len, input int flip_at,
                            output longint first_cyc);
        first_cyc = 0;
        for (int i = 0; i < len; i++) begin
            @(negedge CLK);
            if (i == 0) first_cyc = cyc;
            RX_IN = (i == flip_at) ? ~value : value;
        end
    endtask

    task automatic send_frame(input int presc, input logic [DW-1:0] data, input bit pen,
                              input bit ptyp, input bit par_bit, input bit stop_bit,
                              input int flip_data_bit, output longint start_cyc);
        int     p;
        longint dummy;
        p = eff_prescale(presc);
        PRESCALE = PW'(presc);
        PAR_EN   = pen;
        PAR_TYP  = ptyp;
        send_bit(1'b0, p, -1, start_cyc);
        PRESCALE = PW'($urandom);
        PAR_EN   = 1'($urandom);
        PAR_TYP  = 1'($urandom);
        for (int k = 0; k < DW; k++)
            send_bit(data[k], p, (k == flip_data_bit) ? p / 2 + 1 : -1, dummy);
        if (pen) send_bit(par_bit, p, -1, dummy);
        send_bit(stop_bit, p, -1, dummy);
    endtask

    task automatic test_reset();
        RST = 1'b0;
        idle_cycles(3);
        n_cmp++; if (P_DATA !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_pdata: got %h want 00", P_DATA); end
        n_cmp++; if (DATA_VALID !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %b want 0", DATA_VALID); end
        n_cmp++; if (PAR_ERR !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_parerr: got %b want 0", PAR_ERR); end
        n_cmp++; if (STP_ERR !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_stperr: got %b want 0", STP_ERR); end
        RST = 1'b1;
        idle_cycles(4);
        n_cmp++; if (dv_data.size() != 0) begin n_fail++; $display("[TB] FAIL reset_idle_pulses: got %0d want 0", dv_data.size()); end
    endtask

    task automatic test_basic();
        longint st;
        bit     good;
        dv_data.delete(); dv_cyc.delete();
        send_frame(8, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, -1, st);
        model_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, good);
        idle_cycles(4);
        n_cmp++; if (dv_data.size() != 1) begin n_fail++; $display("[TB] FAIL basic_pulses: got %0d want 1", dv_data.size()); end
        n_cmp++; if (dv_cyc.size() != 1 || dv_cyc[0] - st != 81) begin n_fail++; $display("[TB] FAIL basic_latency: got %0d want 81", (dv_cyc.size() > 0) ? dv_cyc[0] - st : -1); end
        n_cmp++; if (P_DATA !== exp_pdata) begin n_fail++; $display("[TB] FAIL basic_pdata: got %h want %h", P_DATA, exp_pdata); end
        n_cmp++; if (PAR_ERR !== 1'b0 || STP_ERR !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_flags: got %b%b want 00", PAR_ERR, STP_ERR); end
    endtask

    task automatic test_parity();
        longint st;
        bit     good;
        dv_data.delete(); dv_cyc.delete();
        send_frame(16, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, -1, st);
        model_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, good);
        idle_cycles(4);
        n_cmp++; if (dv_data.size() != 1 || P_DATA !== 8'h3C) begin n_fail++; $display("[TB] FAIL par_even_good: got %0d pulses data %h want 1 pulse 3c", dv_data.size(), P_DATA); end
        n_cmp++; if (dv_cyc.size() != 1 || dv_cyc[0] - st != 177) begin n_fail++; $display("[TB] FAIL par_latency: got %0d want 177", (dv_cyc.size() > 0) ? dv_cyc[0] - st : -1); end
        n_cmp++; if (PAR_ERR !== 1'b0) begin n_fail++; $display("[TB] FAIL par_even_flag: got %b want 0", PAR_ERR); end

        dv_data.delete(); dv_cyc.delete();
        send_frame(16, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, -1, st);
        model_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, good);
        idle_cycles(4);
        n_cmp++; if (dv_data.size() != 1 || PAR_ERR !== 1'b0) begin n_fail++; $display("[TB] FAIL par_odd_good: got %0d pulses parerr %b want 1 pulse 0", dv_data.size(), PAR_ERR); end

        dv_data.delete(); dv_cyc.delete();
        send_frame(16, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, -1, st);
        model_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, good);
        idle_cycles(4);
        n_cmp++; if (dv_data.size() != 0) begin n_fail++; $display("[TB] FAIL par_bad_pulses: got %0d want 0", dv_data.size()); end
        n_cmp++; if (PAR_ERR !== 1'b1 || PAR_ERR !== exp_par_err) begin n_fail++; $display("[TB] FAIL par_bad_flag: got %b want 1", PAR_ERR); end
        n_cmp++; if (P_DATA !== 8'h3C) begin n_fail++; $display("[TB] FAIL par_bad_pdata: got %h want 3c", P_DATA); end
        n_cmp++; if (STP_ERR !== 1'b0) begin n_fail++; $display("[TB] FAIL par_bad_stperr: got %b want 0", STP_ERR); end
    endtask

    task automatic test_glitch();
        longint dummy;
        dv_data.delete(); dv_cyc.delete();
        PRESCALE = 6'd16;
        PAR_EN   = 1'b0;
        send_bit(1'b0, 3, -1, dummy);
        idle_cycles(2 * 16 + 4);
        n_cmp++; if (dv_data.size() != 0) begin n_fail++; $display("[TB] FAIL glitch_pulses: got %0d want 0", dv_data.size()); end
        n_cmp++; if (PAR_ERR !== exp_par_err || STP_ERR !== exp_stp_err) begin n_fail++; $display("[TB] FAIL glitch_flags: got %b%b want %b%b", PAR_ERR, STP_ERR, exp_par_err, exp_stp_err); end
        n_cmp++; if (P_DATA !== exp_pdata) begin n_fail++; $display("[TB] FAIL glitch_pdata: got %h want %h", P_DATA, exp_pdata); end
    endtask

    task automatic test_stop_error();
        longint st;
        bit     good;
        dv_data.delete(); dv_cyc.delete();
        send_frame(8, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, -1, st);
        model_frame(8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, good);
        idle_cycles(4);
        n_cmp++; if (dv_data.size() != 0) begin n_fail++; $display("[TB] FAIL stop_bad_pulses: got %0d want 0", dv_data.size()); end
        n_cmp++; if (STP_ERR !== 1'b1) begin n_fail++; $display("[TB] FAIL stop_bad_flag: got %b want 1", STP_ERR); end
        n_cmp++; if (PAR_ERR !== exp_par_err) begin n_fail++; $display("[TB] FAIL stop_bad_parerr: got %b want %b", PAR_ERR, exp_par_err); end
        n_cmp++; if (P_DATA !== exp_pdata) begin n_fail++; $display("[TB] FAIL stop_bad_pdata: got %h want %h", P_DATA, exp_pdata); end

        dv_data.delete(); dv_cyc.delete();
        send_frame(8, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b1, -1, st);
        model_frame(8'h0F, 1'b0, 1'b0, 1'b0, 1'b1, good);
        idle_cycles(4);
        n_cmp++; if (dv_data.size() != 1 || P_DATA !== 8'h0F) begin n_fail++; $display("[TB] FAIL stop_recover: got %0d pulses data %h want 1 pulse 0f", dv_data.size(), P_DATA); end
        n_cmp++; if (STP_ERR !== 1'b0) begin n_fail++; $display("[TB] FAIL stop_recover_flag: got %b want 0", STP_ERR); end
    endtask

    task automatic test_back_to_back();
        longint st1, st2;
        bit     good;
        dv_data.delete(); dv_cyc.delete();
        send_frame(32, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 3, st1);
        send_frame(32, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b1, -1, st2);
        model_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, good);
        model_frame(8'hAA, 1'b0, 1'b0, 1'b0, 1'b1, good);
        idle_cycles(6);
        n_cmp++; if (dv_data.size() != 2) begin n_fail++; $display("[TB] FAIL b2b_pulses: got %0d want 2", dv_data.size()); end
        n_cmp++; if (dv_data.size() < 1 || dv_data[0] !== 8'h55) begin n_fail++; $display("[TB] FAIL b2b_first: got %h want 55", (dv_data.size() > 0) ? dv_data[0] : 8'hxx); end
        n_cmp++; if (dv_data.size() < 2 || dv_data[1] !== 8'hAA) begin n_fail++; $display("[TB] FAIL b2b_second: got %h want aa", (dv_data.size() > 1) ? dv_data[1] : 8'hxx); end
        n_cmp++; if (dv_cyc.size() < 2 || dv_cyc[1] - st2 != 10 * 32 + 2) begin n_fail++; $display("[TB] FAIL b2b_latency: got %0d want %0d", (dv_cyc.size() > 1) ? dv_cyc[1] - st2 : -1, 10 * 32 + 2); end
    endtask

    task automatic test_reset_mid_frame();
        longint    st, dummy;
        bit        good;
        logic [DW-1:0] d;
        d = 8'h81;
        dv_data.delete(); dv_cyc.delete();
        PRESCALE = 6'd8;
        PAR_EN   = 1'b0;
        send_bit(1'b0, 8, -1, st);
        for (int k = 0; k < 4; k++) send_bit(d[k], 8, -1, dummy);
        send_bit(d[4], 3, -1, dummy);
        RST   = 1'b0;
        RX_IN = 1'b1;
        #1;
        exp_pdata = '0; exp_par_err = 1'b0; exp_stp_err = 1'b0;
        n_cmp++; if (P_DATA !== exp_pdata || DATA_VALID !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_data: got %h/%b want 00/0", P_DATA, DATA_VALID); end
        n_cmp++; if (PAR_ERR !== 1'b0 || STP_ERR !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_flags: got %b%b want 00", PAR_ERR, STP_ERR); end
        idle_cycles(3);
        RST = 1'b1;
        idle_cycles(8 * 8);
        n_cmp++; if (dv_data.size() != 0) begin n_fail++; $display("[TB] FAIL midrst_pulses: got %0d want 0", dv_data.size()); end

        send_frame(8, 8'h81, 1'b0, 1'b0, 1'b0, 1'b1, -1, st);
        model_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, good);
        idle_cycles(4);
        n_cmp++; if (dv_data.size() != 1 || P_DATA !== exp_pdata) begin n_fail++; $display("[TB] FAIL midrst_next: got %0d pulses data %h want 1 pulse %h", dv_data.size(), P_DATA, exp_pdata); end
    endtask

    task automatic test_random_frames();
        for (int n = 0; n < 16; n++) begin
            int            sel, presc, p, exp_lat;
            logic [DW-1:0] data;
            bit            pen, ptyp, pbit, sbit, good;
            longint        st;
            sel   = $urandom_range(0, 3);
            presc = (sel == 0) ? 8 : (sel == 1) ? 16 : (sel == 2) ? 32 : $urandom_range(0, 63);
            p     = eff_prescale(presc);
            data  = DW'($urandom);
            pen   = 1'($urandom);
            ptyp  = 1'($urandom);
            pbit  = parity_bit(data, ptyp) ^ ($urandom_range(0, 3) == 0);
            sbit  = ($urandom_range(0, 3) != 0);
            exp_lat = (2 + DW + int'(pen)) * p + 1;
            dv_data.delete(); dv_cyc.delete();
            send_frame(presc, data, pen, ptyp, pbit, sbit, -1, st);
            model_frame(data, pen, ptyp, pbit, sbit, good);
            idle_cycles($urandom_range(4, 7));
            n_cmp++; if (dv_data.size() != (good ? 1 : 0)) begin n_fail++; $display("[TB] FAIL rand%0d_pulses: got %0d want %0d", n, dv_data.size(), good ? 1 : 0); end
            n_cmp++; if (P_DATA !== exp_pdata) begin n_fail++; $display("[TB] FAIL rand%0d_pdata: got %h want %h", n, P_DATA, exp_pdata); end
            n_cmp++; if (PAR_ERR !== exp_par_err || STP_ERR !== exp_stp_err) begin n_fail++; $display("[TB] FAIL rand%0d_flags: got %b%b want %b%b", n, PAR_ERR, STP_ERR, exp_par_err, exp_stp_err); end
            if (good) begin
                n_cmp++; if (dv_cyc.size() != 1 || dv_cyc[0] - st != exp_lat) begin n_fail++; $display("[TB] FAIL rand%0d_latency: got %0d want %0d", n, (dv_cyc.size() > 0) ? dv_cyc[0] - st : -1, exp_lat); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_glitch();
        test_stop_error();
        test_back_to_back();
        test_reset_mid_frame();
        test_random_frames();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
